regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 66 ++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with per-register pending bits; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     ctrl_writeEnable0,
    input  logic [ADDR_W-1:0]        ctrl_writeReg0,
    input  logic [DATA_W-1:0]        data_writeReg0,
    input  logic                     ctrl_writeEnable1,
    input  logic [ADDR_W-1:0]        ctrl_writeReg1,
    input  logic [DATA_W-1:0]        data_writeReg1,
    input  logic                     ctrl_setBusy,
    input  logic [ADDR_W-1:0]        ctrl_busyReg,
    input  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0] data_readReg,
    output logic [NUM_RD-1:0]        busy_read,
    output logic                     busy_any
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              wr0_v, wr1_v, set_v;
    assign wr0_v = ctrl_writeEnable0 && ctrl_writeReg0 != '0;
    assign wr1_v = ctrl_writeEnable1 && ctrl_writeReg1 != '0;
    assign set_v = ctrl_setBusy && ctrl_busyReg != '0;
    // next state: port 0 wins a write collision, setBusy wins over a port-1 clear, register 0 pinned to zero
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = (wr0_v && ctrl_writeReg0 == ADDR_W'(i)) ? data_writeReg0 :
                        (wr1_v && ctrl_writeReg1 == ADDR_W'(i)) ? data_writeReg1 : mem_q[i];
            pend_d[i] = (set_v && ctrl_busyReg == ADDR_W'(i)) ? 1'b1 :
                        (wr1_v && ctrl_writeReg1 == ADDR_W'(i)) ? 1'b0 : pend_q[i];
        end
        mem_d[0]  = '0;
        pend_d[0] = 1'b0;
    end
    // storage and pending bits, cleared asynchronously by reset
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            pend_q <= pend_d;
        end
    end
    assign busy_any = |pend_q;
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = ctrl_readReg[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign rd = (wr0_v && ctrl_writeReg0 == ra) ? data_writeReg0 :
                    (wr1_v && ctrl_writeReg1 == ra) ? data_writeReg1 : mem_q[ra];
`else
        assign rd = mem_q[ra];
`endif
        // forwarded data must not leak out while reset holds the array cleared
        assign data_readReg[k*DATA_W +: DATA_W] = ctrl_reset_n ? rd : '0;
        assign busy_read[k] = pend_q[ra];
    end
endmodule
